// File: rtl/mv_seq_ctrl.sv
// Matrix-vector multiply sequencer: byte-stream load of M (NxN) and v, one shared MAC, row results out on valid/ready.
// Optional MV_SEQ_RELU_EN clamps negative row results to zero on out_data.
module mv_seq_ctrl #(
    parameter int N     = 2,
    parameter int W     = 4,
    parameter int ACC_W = 2*W+2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             keep_m,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = $clog2(N*N);
    localparam int K_W   = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_M, S_LOAD_V, S_MAC, S_OUT, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [N*N-1:0][W-1:0]    m_q, m_d;
    logic [N-1:0][W-1:0]      v_q, v_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic [K_W-1:0]           i_q, i_d, k_q, k_d;
    logic                     in_ready_q, in_ready_d;

    logic                     take;
    logic [IDX_W-1:0]         m_sel;
    logic signed [W-1:0]      m_elem, v_elem;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  res;
    logic                     unused_hi;

    assign unused_hi = ^in_data[7:W];
    assign take      = in_valid & in_ready_q;

    // Elements are stored raw; sign extension happens at the multiplier.
    assign m_sel    = IDX_W'(i_q) * IDX_W'(N) + IDX_W'(k_q);
    assign m_elem   = m_q[m_sel];
    assign v_elem   = v_q[k_q];
    assign prod     = m_elem * v_elem;
    assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        v_d     = v_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = keep_m ? S_LOAD_V : S_LOAD_M;
                end
            end
            S_LOAD_M: begin
                if (take) begin
                    m_d[cnt_q] = in_data[W-1:0];
                    if (cnt_q == IDX_W'(N*N-1)) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_V;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            S_LOAD_V: begin
                if (take) begin
                    v_d[cnt_q[K_W-1:0]] = in_data[W-1:0];
                    if (cnt_q == IDX_W'(N-1)) begin
                        i_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (k_q == K_W'(N-1)) state_d = S_OUT;
                else                  k_d     = k_q + K_W'(1);
            end
            S_OUT: begin
                if (out_ready) begin
                    if (i_q == K_W'(N-1)) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + K_W'(1);
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_LOAD_M) || (state_d == S_LOAD_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            v_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            i_q        <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            v_q        <= v_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            k_q        <= k_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef MV_SEQ_RELU_EN
    assign res = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    assign res = acc_q;
`endif

    // out_data reads zero whenever no result is being offered.
    assign out_data  = (state_q == S_OUT) ? res : '0;
    assign out_valid = (state_q == S_OUT);
    assign in_ready  = in_ready_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_mv_seq_ctrl.sv
// Bench for mv_seq_ctrl: job-level reference model checked every cycle, plus literal scenario checks.
module tb_mv_seq_ctrl;
    localparam int N = 2, W = 4, ACC_W = 10;

    logic clk = 1'b0, rst = 1'b1;
    logic start, start_m = 1'b0, start_n = 1'b0, keep_m = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic in_ready, out_valid, busy, done;
    logic [ACC_W-1:0] out_data;

    assign start = start_m | start_n;

    mv_seq_ctrl #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .keep_m(keep_m),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at t=%0t",
                      name, got, got, exp, exp, $time);
    endtask

    function automatic int sx(input logic [7:0] d);
        logic signed [W-1:0] t;
        t = d[W-1:0];
        return int'(t);
    endfunction

    function automatic logic [ACC_W-1:0] fmt(input int y);
        int t;
        t = y;
`ifdef MV_SEQ_RELU_EN
        if (t < 0) t = 0;
`endif
        return t[ACC_W-1:0];
    endfunction

    // Reference model: stored operands, pending row results and timing counters.
    int mm[N*N];
    int vv[N];
    int exp_q[$], got_q[$], mdl_q[$], rise_q[$];
    int load_left = 0, pos = 0, wait_c = 0, cyc = 0, fin_cyc = 0;
    int done_tot = 0, busy_tot = 0, acc_tot = 0, ov_tot = 0;
    bit presenting = 0, job_active = 0, done_now = 0, ov_prev = 0;
    bit ev_start = 0, ev_keep = 0, ev_acc = 0, ev_hs = 0;
    logic [7:0] ev_data = 8'h00;
    logic [ACC_W-1:0] ev_od = '0;
    bit e_ir, e_ov, e_busy, e_done;
    logic [ACC_W-1:0] e_od;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            foreach (mm[j]) mm[j] = 0;
            foreach (vv[j]) vv[j] = 0;
            exp_q.delete();
            load_left = 0; pos = 0; wait_c = 0;
            presenting = 0; job_active = 0; done_now = 0;
        end else begin
            if (done_now) begin
                done_now = 0;
                job_active = 0;
            end
            if (ev_start) begin
                job_active = 1;
                load_left = ev_keep ? N : N*N + N;
                pos = ev_keep ? N*N : 0;
            end
            if (ev_acc) begin
                if (pos < N*N) mm[pos] = sx(ev_data);
                else           vv[pos-N*N] = sx(ev_data);
                pos++;
                load_left--;
                if (load_left == 0) begin
                    mdl_q.delete();
                    for (int r = 0; r < N; r++) begin
                        int s;
                        s = 0;
                        for (int c = 0; c < N; c++) s += mm[r*N+c] * vv[c];
                        exp_q.push_back(s);
                        mdl_q.push_back(s);
                    end
                    wait_c = 0;
                    fin_cyc = cyc;
                end
            end else if (exp_q.size() > 0 && !presenting) begin
                wait_c++;
                if (wait_c == N) presenting = 1;
            end
            if (ev_hs) begin
                got_q.push_back(int'(ev_od));
                void'(exp_q.pop_front());
                presenting = 0;
                wait_c = 0;
                if (exp_q.size() == 0) done_now = 1;
            end
        end

        e_ir   = job_active && (load_left > 0);
        e_ov   = presenting;
        e_od   = presenting ? fmt(exp_q[0]) : '0;
        e_busy = job_active;
        e_done = done_now;
        chk("cyc_in_ready", in_ready, e_ir);
        chk("cyc_out_valid", out_valid, e_ov);
        chk("cyc_out_data", out_data, e_od);
        chk("cyc_busy", busy, e_busy);
        chk("cyc_done", done, e_done);

        if (out_valid && !ov_prev) rise_q.push_back(cyc);
        ov_prev = out_valid;
        if (done) done_tot++;
        if (busy) busy_tot++;
        if (out_valid) ov_tot++;
        if (in_valid && in_ready) acc_tot++;

        ev_start = !rst && start && !job_active;
        ev_keep  = keep_m;
        ev_acc   = !rst && in_valid && e_ir;
        ev_hs    = !rst && e_ov && out_ready;
        ev_data  = in_data;
        ev_od    = out_data;
    end

    // out_ready: 0 = tied high, 1 = random, 2 = hold low for 5 cycles of each result.
    int rdy_mode = 0, ov_run = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid) ov_run++;
                else           ov_run = 0;
                out_ready = (ov_run > 5);
            end
        endcase
    end

    // Spurious start pulses, only while a job is running and not in its last cycle.
    bit noise_en = 0;
    initial forever begin
        @(posedge clk); #1;
        start_n = noise_en && busy && !done && !rst && ($urandom_range(0, 1) == 1);
    end

    int load_q[$];

    task automatic drive_elem(input int idx, input bit gaps, input int hi_mode);
        logic [31:0] v;
        logic [3:0] hi;
        v = load_q[idx];
        hi = (hi_mode == 0) ? 4'($urandom) : ((idx % 2 == 1) ? 4'hF : 4'h0);
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data = {hi, v[3:0]};
    endtask

    task automatic send_job(input bit keep, input bit gaps, input int hi_mode);
        int idx, t;
        bit a;
        idx = 0;
        t = 0;
        @(posedge clk); #1;
        start_m = 1'b1;
        keep_m = keep;
        drive_elem(idx, gaps, hi_mode);
        while (idx < load_q.size() && t < 300) begin
            @(negedge clk); #1;
            a = in_valid && in_ready;
            @(posedge clk); #1;
            start_m = 1'b0;
            if (a) idx++;
            if (idx < load_q.size()) drive_elem(idx, gaps, hi_mode);
            else in_valid = 1'b0;
            t++;
        end
        start_m = 1'b0;
        in_valid = 1'b0;
        chk("load_elements", idx, load_q.size());
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (busy && t < 300);
        chk("job_completes", busy, 1'b0);
    endtask

    int b, rb, d0, bz0, a0, o0, t;
    logic [ACC_W-1:0] neg_exp;

    initial begin
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic job
        load_q = '{1, 2, 3, 4, 5, 6};
        rdy_mode = 0;
        b = got_q.size(); rb = rise_q.size(); d0 = done_tot; bz0 = busy_tot;
        send_job(1'b0, 1'b0, 0);
        wait_idle();
        chk("basic_y0", got_q[b], 17);
        chk("basic_y1", got_q[b+1], 39);
        chk("model_y0", mdl_q[0], 17);
        chk("model_y1", mdl_q[1], 39);
        chk("basic_done_pulses", done_tot - d0, 1);
        chk("basic_busy_cycles", busy_tot - bz0, N*N + N + N*(N+1) + 1);
        chk("basic_first_latency", rise_q[rb] - fin_cyc, N);
        chk("basic_row_spacing", rise_q[rb+1] - rise_q[rb], N + 1);

        // Reuse matrix, with spurious starts while busy
        load_q = '{1, 1};
        noise_en = 1;
        b = got_q.size(); a0 = acc_tot; d0 = done_tot;
        send_job(1'b1, 1'b0, 0);
        wait_idle();
        noise_en = 0;
        chk("reuse_y0", got_q[b], 3);
        chk("reuse_y1", got_q[b+1], 7);
        chk("reuse_accepts", acc_tot - a0, 2);
        chk("reuse_done_pulses", done_tot - d0, 1);

        // Signed extremes, upper nibble alternating 0x0/0xF
        load_q = '{-8, 7, -1, 0, -8, -8};
        b = got_q.size();
        send_job(1'b0, 1'b0, 1);
        wait_idle();
        chk("signed_y0", got_q[b], 8);
        chk("signed_y1", got_q[b+1], 8);
        chk("model_signed_y0", mdl_q[0], 8);

        // Negative result with output stalls and input gaps
`ifdef MV_SEQ_RELU_EN
        neg_exp = '0;
`else
        neg_exp = 10'h3FD;
`endif
        load_q = '{-1, 0, 0, 1, 3, 3};
        rdy_mode = 2;
        b = got_q.size(); o0 = ov_tot; a0 = acc_tot;
        send_job(1'b0, 1'b1, 0);
        wait_idle();
        rdy_mode = 0;
        chk("neg_y0", got_q[b], neg_exp);
        chk("neg_y1", got_q[b+1], 3);
        chk("stall_valid_cycles", ov_tot - o0, 2*6);
        chk("gap_accepts", acc_tot - a0, N*N + N);

        // Random jobs
        rdy_mode = 1;
        for (int j = 0; j < 10; j++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            load_q.delete();
            for (int e = 0; e < (keep ? N : N*N + N); e++)
                load_q.push_back(int'($urandom_range(0, 15)) - 8);
            b = got_q.size();
            send_job(keep, 1'b1, 0);
            wait_idle();
            chk("rand_rows", got_q.size() - b, N);
        end
        rdy_mode = 0;

        // Reset during the MAC of row 1
        load_q = '{3, -2, 7, 5, -4, 6};
        b = got_q.size(); d0 = done_tot;
        send_job(1'b0, 1'b0, 0);
        t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (got_q.size() == b && t < 50);
        chk("midrst_row0_seen", got_q.size() - b, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_done", done, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_no_done", done_tot - d0, 0);
        load_q = '{5, 6};
        b = got_q.size();
        send_job(1'b1, 1'b0, 0);
        wait_idle();
        chk("postrst_y0", got_q[b], 0);
        chk("postrst_y1", got_q[b+1], 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
